// File: rtl/nn_pkg.sv
// nn_pkg: shared neural-layer widths, activation type and a width-generic signed saturation helper.
package nn_pkg;

    localparam int ACT_W = 8;
    localparam int WGT_W = 8;
    localparam int ACC_W = 24;

    typedef logic signed [ACT_W-1:0] act_t;

    // Caller sign-extends into 64 bits and truncates the result back to w bits.
    function automatic logic signed [63:0] sat_signed(input logic signed [63:0] v, input int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        return (v > hi) ? hi : ((v < lo) ? lo : v);
    endfunction

endpackage

// File: rtl/neuron_requant.sv
// neuron_requant: combinational arithmetic shift, optional round-half-up and saturation.
// Rounding is enabled by defining NEURON_MAC_ROUND_EN.
module neuron_requant
    import nn_pkg::sat_signed;
#(
    parameter int ACC_W     = 24,
    parameter int SHIFT     = 7,
    parameter int OUT_DAT_W = 8
) (
    input  logic signed [ACC_W-1:0]     sum,
    output logic signed [OUT_DAT_W-1:0] y
);

    logic signed [ACC_W:0] ext;
    logic signed [ACC_W:0] s;

`ifdef NEURON_MAC_ROUND_EN
    // One extra bit keeps the rounding offset from overflowing the accumulator range.
    localparam int HS = (SHIFT > 0) ? SHIFT - 1 : 0;
    localparam logic signed [ACC_W:0] HALF = (ACC_W + 1)'((SHIFT > 0) ? 1 : 0) <<< HS;
    assign ext = (ACC_W + 1)'(sum) + HALF;
`else
    assign ext = (ACC_W + 1)'(sum);
`endif

    assign s = ext >>> SHIFT;
    assign y = OUT_DAT_W'(sat_signed(64'(s), OUT_DAT_W));

endmodule

// File: rtl/neuron_mac.sv
// neuron_mac: streaming multiply-accumulate neuron with bias, requantisation and saturation.
// Define NEURON_MAC_ROUND_EN to round half up before the requantisation shift.
module neuron_mac #(
    parameter int IN_DAT_W  = 8,
    parameter int W_DAT_W   = 8,
    parameter int BIAS_W    = 16,
    parameter int N_INPUTS  = 16,
    parameter int ACC_W     = 24,
    parameter int SHIFT     = 7,
    parameter int OUT_DAT_W = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic signed [IN_DAT_W-1:0]  in_x,
    input  logic signed [W_DAT_W-1:0]   in_w,
    input  logic                        in_valid,
    input  logic signed [BIAS_W-1:0]    bias,
    input  logic                        sync_clr,
    output logic signed [OUT_DAT_W-1:0] out_y,
    output logic                        out_valid,
    output logic                        busy
);

    localparam int CW = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;

    if (N_INPUTS < 1 || ACC_W < IN_DAT_W + W_DAT_W + $clog2(N_INPUTS) + 1 || ACC_W < BIAS_W + 1) begin : g_cfg_check
        $error("neuron_mac: N_INPUTS must be >= 1 and ACC_W wide enough for the product sum and bias");
    end

    logic [CW-1:0]                  cnt;
    logic signed [ACC_W-1:0]        acc;
    logic signed [IN_DAT_W+W_DAT_W-1:0] prod;
    logic signed [ACC_W-1:0]        sum;
    logic signed [OUT_DAT_W-1:0]    req_y;
    logic                           last;

    assign prod = in_x * in_w;
    // Beat 0 starts from the bias, which also covers the single-input neuron.
    assign sum  = ((cnt == '0) ? ACC_W'(bias) : acc) + ACC_W'(prod);
    assign last = (cnt == CW'(N_INPUTS - 1));
    assign busy = (cnt != '0);

    neuron_requant #(
        .ACC_W    (ACC_W),
        .SHIFT    (SHIFT),
        .OUT_DAT_W(OUT_DAT_W)
    ) u_requant (
        .sum(sum),
        .y  (req_y)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            acc       <= '0;
            out_y     <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (sync_clr) begin
                cnt <= '0;
                acc <= '0;
            end else if (in_valid) begin
                acc <= sum;
                cnt <= last ? '0 : cnt + 1'b1;
                if (last) begin
                    out_y     <= req_y;
                    out_valid <= 1'b1;
                end
            end
        end
    end

endmodule
